// File: rtl/syrk_src_pkg.sv
// Shared definitions for the syrk input-stream stimulus source:
// LFSR constants, run-state encoding and the seed/step helpers.
package syrk_src_pkg;

    localparam logic [31:0] LFSR_POLY    = 32'hA3000000;
    localparam logic [31:0] GOLDEN_RATIO = 32'h9E3779B9;

    // Wide enough for WORDS up to 2^20 inclusive.
    localparam int unsigned REM_W = 21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One Galois step, right-shifting, taps folded in when bit 0 falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        logic [31:0] shifted;
        shifted = {1'b0, x[31:1]};
        return x[0] ? (shifted ^ LFSR_POLY) : shifted;
    endfunction

    // Per-channel seed; an all-zero LFSR would lock up, so zero maps to one.
    function automatic logic [31:0] seed_of(input logic [31:0] base, input logic [31:0] idx);
        logic [31:0] s;
        s = base ^ (idx * GOLDEN_RATIO);
        return (s == 32'h00000000) ? 32'h00000001 : s;
    endfunction

endpackage

// File: rtl/syrk_src_chan.sv
// One ap_fifo read-side stream: LFSR data, remaining-word counter,
// optional one-cycle bubble after each accepted word.
module syrk_src_chan
    import syrk_src_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned WORDS   = 1024,
    parameter logic [31:0] CH_SEED = 32'h00000001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              gap_en,
    input  logic              read,
    output logic              accept,
    output logic              fin,
    output logic              empty_n,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned      CW       = (DATA_W < 32) ? DATA_W : 32;
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(WORDS);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1'b1);
    localparam logic [REM_W-1:0] REM_ZERO = {REM_W{1'b0}};

    logic [31:0]       lfsr_r;
    logic [31:0]       lfsr_step_s;
    logic [REM_W-1:0]  rem_r;
    logic              bubble_r;
    logic              empty_n_r;
    logic [DATA_W-1:0] dout_r;

    // Narrow or zero-extend a 32-bit LFSR value to the channel word width.
    function automatic logic [DATA_W-1:0] to_word(input logic [31:0] x);
        return DATA_W'(x[CW-1:0]);
    endfunction

    assign lfsr_step_s = lfsr_next(lfsr_r);
    assign accept      = read & empty_n_r;
    // High when the remaining count will be zero after this cycle.
    assign fin         = (rem_r == REM_ZERO) || ((rem_r == REM_ONE) && accept);
    assign empty_n     = empty_n_r;
    assign dout        = dout_r;

    // Channel state: reload on run start, step/decrement on accept, clear bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r    <= CH_SEED;
            rem_r     <= REM_ZERO;
            bubble_r  <= 1'b0;
            empty_n_r <= 1'b0;
            dout_r    <= {DATA_W{1'b0}};
        end else if (load) begin
            lfsr_r    <= CH_SEED;
            rem_r     <= REM_INIT;
            bubble_r  <= 1'b0;
            empty_n_r <= (REM_INIT != REM_ZERO);
            dout_r    <= to_word(CH_SEED);
        end else if (accept) begin
            lfsr_r    <= lfsr_step_s;
            rem_r     <= rem_r - REM_ONE;
            bubble_r  <= gap_en;
            empty_n_r <= (rem_r != REM_ONE) && !gap_en;
            dout_r    <= to_word(lfsr_step_s);
        end else begin
            lfsr_r    <= lfsr_r;
            rem_r     <= rem_r;
            bubble_r  <= 1'b0;
            // A bubble only ever hides a word that is still owed.
            empty_n_r <= bubble_r ? (rem_r != REM_ZERO) : empty_n_r;
            dout_r    <= dout_r;
        end
    end

endmodule

// File: rtl/syrk_in_stream_src.sv
// Pseudo-random stimulus source feeding the syrk kernel's ap_fifo inputs.
// Run control FSM, accepted-word counter and read-while-empty flag live
// here; each channel is an independent syrk_src_chan.
module syrk_in_stream_src
    import syrk_src_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_CH   = 8,
    parameter int unsigned WORDS  = 1024,
    parameter logic [31:0] SEED   = 32'h00000001
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     start,
    input  logic                     gap_en,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_err,
    output logic [31:0]              words_sent,
    output logic [N_CH*DATA_W-1:0]   A_in_dout,
    output logic [N_CH-1:0]          A_in_empty_n,
    input  logic [N_CH-1:0]          A_in_read
);

    state_t      state_r;
    logic        busy_r;
    logic        done_r;
    logic        rd_err_r;
    logic [31:0] words_sent_r;

    logic            load_s;
    logic            all_fin_s;
    logic            bad_read_s;
    logic [N_CH-1:0] accept_s;
    logic [N_CH-1:0] fin_s;
    logic [32:0]     sum_s;
    logic [31:0]     words_next_s;

    assign load_s     = start && (state_r == IDLE);
    assign all_fin_s  = &fin_s;
    assign bad_read_s = |(A_in_read & ~A_in_empty_n);

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_chan
            syrk_src_chan #(
                .DATA_W  (DATA_W),
                .WORDS   (WORDS),
                .CH_SEED (seed_of(SEED, 32'(i)))
            ) u_chan (
                .clk     (ap_clk),
                .rst     (ap_rst),
                .load    (load_s),
                .gap_en  (gap_en),
                .read    (A_in_read[i]),
                .accept  (accept_s[i]),
                .fin     (fin_s[i]),
                .empty_n (A_in_empty_n[i]),
                .dout    (A_in_dout[i*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // Add this cycle's accept count to the running total, clamping at all-ones.
    always_comb begin
        sum_s = {1'b0, words_sent_r};
        for (int i = 0; i < N_CH; i++) begin
            sum_s = sum_s + {32'h00000000, accept_s[i]};
        end
        if (sum_s[32]) begin
            words_next_s = 32'hFFFFFFFF;
        end else begin
            words_next_s = sum_s[31:0];
        end
    end

    // Run sequencing with registered busy/done; start only counts in IDLE.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if (all_fin_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Accepted-word total, cleared when a run starts.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            words_sent_r <= 32'h00000000;
        end else if (load_s) begin
            words_sent_r <= 32'h00000000;
        end else begin
            words_sent_r <= words_next_s;
        end
    end

    // Sticky read-while-empty flag; a new run clears history but still sees this cycle.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rd_err_r <= 1'b0;
        end else if (load_s) begin
            rd_err_r <= bad_read_s;
        end else begin
            rd_err_r <= rd_err_r | bad_read_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign rd_err     = rd_err_r;
    assign words_sent = words_sent_r;

endmodule

// File: tb/tb_syrk_in_stream_src.sv
// Self-checking bench for syrk_in_stream_src (WORDS=8, 8 channels, 32-bit).
// A transaction-level model predicts every output each cycle; directed
// phases add hand-computed expectations.
module tb_syrk_in_stream_src;

    localparam int          DW   = 32;
    localparam int          NC   = 8;
    localparam int          NW   = 8;
    localparam logic [31:0] SEED = 32'h00000001;

    logic              ap_clk = 1'b0;
    logic              ap_rst = 1'b1;
    logic              start  = 1'b0;
    logic              gap_en = 1'b0;
    logic              busy;
    logic              done;
    logic              rd_err;
    logic [31:0]       words_sent;
    logic [NC*DW-1:0]  A_in_dout;
    logic [NC-1:0]     A_in_empty_n;
    logic [NC-1:0]     A_in_read = '0;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    syrk_in_stream_src #(
        .DATA_W (DW),
        .N_CH   (NC),
        .WORDS  (NW),
        .SEED   (SEED)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .start        (start),
        .gap_en       (gap_en),
        .busy         (busy),
        .done         (done),
        .rd_err       (rd_err),
        .words_sent   (words_sent),
        .A_in_dout    (A_in_dout),
        .A_in_empty_n (A_in_empty_n),
        .A_in_read    (A_in_read)
    );

    always #5 ap_clk = ~ap_clk;

    // ---------------- reference model ----------------
    int          m_state;      // 0 idle, 1 run, 2 done
    int          m_rem  [NC];
    logic [31:0] m_lfsr [NC];
    logic [31:0] m_dout [NC];
    bit          m_bub  [NC];
    longint      m_ws;
    bit          m_err;

    function automatic logic [31:0] step_ref(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'hA3000000 : 32'h00000000);
    endfunction

    function automatic logic [31:0] seed_ref(input int i);
        logic [31:0] s;
        s = SEED ^ (32'(i) * 32'h9E3779B9);
        if (s == 32'h0) s = 32'h1;
        return s;
    endfunction

    function automatic logic [31:0] ref_after(input int i, input int n);
        logic [31:0] w;
        w = seed_ref(i);
        for (int k = 0; k < n; k++) w = step_ref(w);
        return w;
    endfunction

    function automatic bit m_avail(input int i);
        return (m_state == 1) && (m_rem[i] != 0) && !m_bub[i];
    endfunction

    function automatic logic [31:0] dout_of(input int i);
        return A_in_dout[i*DW +: DW];
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    initial begin : model
        bit acc [NC];
        bit bad;
        int nacc;
        bit all_zero;
        forever begin
            @(posedge ap_clk or posedge ap_rst);
            if (ap_rst) begin
                m_state = 0;
                m_ws    = 0;
                m_err   = 1'b0;
                for (int i = 0; i < NC; i++) begin
                    m_rem[i]  = 0;
                    m_lfsr[i] = seed_ref(i);
                    m_dout[i] = 32'h0;
                    m_bub[i]  = 1'b0;
                end
            end else begin
                bad  = 1'b0;
                nacc = 0;
                for (int i = 0; i < NC; i++) begin
                    acc[i] = A_in_read[i] && m_avail(i);
                    if (A_in_read[i] && !m_avail(i)) bad = 1'b1;
                    if (acc[i]) nacc++;
                end
                if (m_state == 0 && start) begin
                    for (int i = 0; i < NC; i++) begin
                        m_rem[i]  = NW;
                        m_lfsr[i] = seed_ref(i);
                        m_dout[i] = m_lfsr[i];
                        m_bub[i]  = 1'b0;
                    end
                    m_ws    = 0;
                    m_err   = 1'b0;
                    m_state = 1;
                end else begin
                    for (int i = 0; i < NC; i++) begin
                        if (acc[i]) begin
                            m_lfsr[i] = step_ref(m_lfsr[i]);
                            m_dout[i] = m_lfsr[i];
                            m_rem[i]  = m_rem[i] - 1;
                            m_bub[i]  = gap_en;
                        end else begin
                            m_bub[i]  = 1'b0;
                        end
                    end
                    m_ws = m_ws + nacc;
                    if (m_ws > 64'hFFFFFFFF) m_ws = 64'hFFFFFFFF;
                    if (m_state == 1) begin
                        all_zero = 1'b1;
                        for (int i = 0; i < NC; i++) if (m_rem[i] != 0) all_zero = 1'b0;
                        if (all_zero) m_state = 2;
                    end else if (m_state == 2) begin
                        m_state = 0;
                    end
                end
                if (bad) m_err = 1'b1;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin : compare
        logic [NC*DW-1:0] ed;
        logic [NC-1:0]    ee;
        forever begin
            @(negedge ap_clk);
            if (chk_en) begin
                for (int i = 0; i < NC; i++) begin
                    ed[i*DW +: DW] = m_dout[i];
                    ee[i]          = m_avail(i);
                end
                check("cmp_busy",       busy,         (m_state == 1));
                check("cmp_done",       done,         (m_state == 2));
                check("cmp_rd_err",     rd_err,       m_err);
                check("cmp_words_sent", words_sent,   m_ws[31:0]);
                check("cmp_empty_n",    A_in_empty_n, ee);
                check("cmp_dout",       A_in_dout,    ed);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Consume whatever is offered until done, bounded.
    task automatic drain();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            A_in_read = A_in_empty_n;
            tick();
            if (done) seen = 1'b1;
        end
        A_in_read = '0;
        check("drain_done_seen", seen, 1'b1);
        tick();
    endtask

    int         n_acc, n_done, done_at, c0, c7, nq;
    logic [5:0] pat;
    logic [31:0] w;
    logic [NC-1:0] r;

    initial begin
        // reset
        tick(); tick();
        chk_en = 1'b1;
        check("rst_busy",    busy,         1'b0);
        check("rst_empty_n", A_in_empty_n, 8'h00);
        check("rst_dout",    A_in_dout,    256'h0);
        check("rst_words",   words_sent,   32'h0);
        #2 ap_rst = 1'b0;
        tick();

        // phase 1: ch0 sequence
        start = 1'b1; tick(); start = 1'b0;
        check("p1_busy",     busy,         1'b1);
        check("p1_empty_n",  A_in_empty_n, 8'hFF);
        check("p1_dout0_w0", dout_of(0),   32'h00000001);
        A_in_read = 8'h01; tick();
        check("p1_dout0_w1", dout_of(0),   32'hA3000000);
        tick();
        check("p1_dout0_w2", dout_of(0),   32'h51800000);
        check("p1_empty0",   A_in_empty_n[0], 1'b1);
        A_in_read = '0;
        drain();
        check("p1_busy_end", busy, 1'b0);

        // phase 2: full-rate run on all channels
        start = 1'b1; tick(); start = 1'b0;
        n_acc = 0; n_done = 0; done_at = 0;
        for (int k = 1; k <= 14; k++) begin
            A_in_read = A_in_empty_n;
            n_acc += $countones(A_in_empty_n);
            tick();
            if (done) begin n_done++; done_at = k + 1; end
        end
        A_in_read = '0;
        check("p2_accepts",    n_acc,      64);
        check("p2_done_count", n_done,     1);
        check("p2_done_cycle", done_at,    9);
        check("p2_words_sent", words_sent, 32'd64);
        check("p2_busy",       busy,       1'b0);
        check("p2_rd_err",     rd_err,     1'b0);

        // phase 4: read on ch5 while idle
        A_in_read = 8'h20; tick(); A_in_read = '0;
        check("p4_err_set",    rd_err,          1'b1);
        check("p4_empty5",     A_in_empty_n[5], 1'b0);
        tick();
        check("p4_err_sticky", rd_err,          1'b1);
        check("p4_dout5_hold", dout_of(5),      ref_after(5, NW));
        start = 1'b1; tick(); start = 1'b0;
        check("p4_err_clear",  rd_err,          1'b0);
        check("p4_seed5",      dout_of(5),      32'h1715609C);
        drain();
        check("p4_err_after",  rd_err,          1'b0);

        // phase 3: gap_en with ch3 read held high
        gap_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        A_in_read = 8'h08; pat = '0; nq = 0; w = seed_ref(3);
        for (int j = 0; j < 6; j++) begin
            pat = {pat[4:0], A_in_empty_n[3]};
            if (A_in_empty_n[3]) begin
                check("p3_data", dout_of(3), w);
                w = step_ref(w);
                nq++;
            end
            tick();
        end
        A_in_read = '0;
        check("p3_pattern",    pat,        6'b101010);
        check("p3_accepts",    nq,         3);
        check("p3_words_sent", words_sent, 32'd3);
        check("p3_rd_err",     rd_err,     1'b1);
        drain();
        gap_en = 1'b0;

        // phase 5: uneven consumption, then start during DONE
        start = 1'b1; tick(); start = 1'b0;
        c0 = 0; c7 = 0; n_done = 0; done_at = 0;
        for (int k = 1; k <= 40 && n_done == 0; k++) begin
            r = '0;
            if (c0 < NW) begin r = 8'h7F; c0++; end
            if ((k % 4 == 1) && c7 < NW) begin r[7] = 1'b1; c7++; end
            A_in_read = r;
            tick();
            if (k + 1 == 9) begin
                check("p5_ch0_empty", A_in_empty_n[0], 1'b0);
                check("p5_ch7_live",  A_in_empty_n[7], 1'b1);
                check("p5_busy",      busy,            1'b1);
            end
            if (done) begin n_done++; done_at = k + 1; end
        end
        A_in_read = '0;
        check("p5_done_cycle", done_at, 30);
        check("p5_rd_err",     rd_err,  1'b0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("p5_start_in_done_ignored", busy,         1'b0);
        check("p5_idle_empty",            A_in_empty_n, 8'h00);

        // phase 6: reset mid-run
        start = 1'b1; tick(); start = 1'b0;
        A_in_read = 8'h03;
        repeat (5) tick();
        A_in_read = '0;
        check("p6_words_10", words_sent, 32'd10);
        #2 ap_rst = 1'b1;
        #1;
        check("p6_rst_busy",    busy,         1'b0);
        check("p6_rst_done",    done,         1'b0);
        check("p6_rst_words",   words_sent,   32'h0);
        check("p6_rst_empty_n", A_in_empty_n, 8'h00);
        check("p6_rst_dout",    A_in_dout,    256'h0);
        n_done = 0;
        repeat (3) begin tick(); if (done) n_done++; end
        check("p6_no_done", n_done, 0);
        #2 ap_rst = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        check("p6_seed0", dout_of(0), 32'h00000001);
        check("p6_seed5", dout_of(5), 32'h1715609C);
        A_in_read = 8'h01; tick(); A_in_read = '0;
        check("p6_step0", dout_of(0), 32'hA3000000);
        drain();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
